// File: rtl/stress_pkg.sv
// Shared types and constants for the toggle-array power stress block.
//   mode_t     : requested activity mode (OFF / RAMP / FULL / PULSE)
//   state_t    : soft-start controller states
//   lfsr_taps  : maximal-length Fibonacci tap mask for 2..32-bit LFSRs
//   PHASE_BITS : width of the PULSE duty-cycle phase counter
package stress_pkg;

  localparam int unsigned PHASE_BITS = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_FULL  = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Bit n-1 set means register bit n feeds the XOR feedback.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/stress_channel.sv
// One toggle channel: a WIDTH-bit register that advances when run is high.
// Binary counter by default; a maximal-length Fibonacci LFSR when
// STRESS_LFSR_EN is defined.
//   clk, reset_n : clock, synchronous active-low reset (loads seed)
//   run          : advance this cycle
//   seed         : reset value (must be nonzero in LFSR builds)
//   value        : current register contents
module stress_channel
  import stress_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

`ifdef STRESS_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
`endif

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next value: hold, or advance by one step.
  always_comb begin
    value_d = value_q;
    if (run) begin
`ifdef STRESS_LFSR_EN
      value_d = {value_q[WIDTH-2:0], ^(value_q & TAPS)};
`else
      value_d = value_q + WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) value_q <= seed;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/stress_toggle_array.sv
// Array of NUM_CHANNELS toggling registers for supply-current stress tests,
// with a soft-start ramp that enables channels one at a time and an optional
// duty-cycled (PULSE) mode. Define STRESS_LFSR_EN to make each channel an LFSR.
//   clk, reset_n    : clock, synchronous active-low reset
//   enable          : run request; low returns to IDLE
//   mode            : 0=OFF 1=RAMP 2=FULL 3=PULSE
//   duty            : PULSE on-cycles per 256-cycle period
//   active_channels : number of channels currently enabled
//   ramp_done       : all channels enabled after a RAMP
//   signature       : registered XOR of every channel bit
//   heartbeat       : MSB of channel 0
module stress_toggle_array
  import stress_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 32,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned RAMP_CYCLES  = 6000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic [1:0]                          mode,
  input  logic [PHASE_BITS-1:0]               duty,
  output logic [$clog2(NUM_CHANNELS+1)-1:0]   active_channels,
  output logic                                ramp_done,
  output logic                                signature,
  output logic                                heartbeat
);

  localparam int unsigned ACT_W   = $clog2(NUM_CHANNELS + 1);
  localparam int unsigned TIMER_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [ACT_W-1:0]      active_q, active_d;
  logic                  ramp_done_q, ramp_done_d;
  logic                  sig_q, sig_c;
  logic                  gate_c;
  mode_t                 mode_in;

  logic [NUM_CHANNELS-1:0] run;
  logic [WIDTH-1:0]        ch_val [NUM_CHANNELS];

  assign mode_in = mode_t'(mode);

  // Next-state logic for the soft-start controller.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    timer_d     = timer_q;
    phase_d     = phase_q;
    active_d    = active_q;
    ramp_done_d = ramp_done_q;
    case (state_q)
      S_IDLE: begin
        active_d    = '0;
        ramp_done_d = 1'b0;
        if (enable && (mode_in != MODE_OFF)) begin
          mode_d = mode_in;
          if (mode_in == MODE_RAMP) begin
            state_d = S_RAMP;
            timer_d = '0;
          end else begin
            state_d  = S_HOLD;
            active_d = ACT_W'(NUM_CHANNELS);
            phase_d  = '0;
          end
        end
      end
      S_RAMP: begin
        if (timer_q == TIMER_W'(RAMP_CYCLES - 1)) begin
          timer_d  = '0;
          active_d = active_q + ACT_W'(1);
          if ((active_q + ACT_W'(1)) == ACT_W'(NUM_CHANNELS)) begin
            state_d     = S_HOLD;
            ramp_done_d = 1'b1;
            phase_d     = '0;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_HOLD: begin
        phase_d     = phase_q + PHASE_BITS'(1);
        ramp_done_d = (mode_q == MODE_RAMP);
      end
      default: state_d = S_IDLE;
    endcase
    // A dropped request or a mode change aborts through a one-cycle IDLE.
    if ((state_q != S_IDLE) && (!enable || (mode_in != mode_q))) begin
      state_d     = S_IDLE;
      active_d    = '0;
      ramp_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_OFF;
      timer_q     <= '0;
      phase_q     <= '0;
      active_q    <= '0;
      ramp_done_q <= 1'b0;
      sig_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      active_q    <= active_d;
      ramp_done_q <= ramp_done_d;
      sig_q       <= sig_c;
    end
  end

  assign gate_c = (mode_q != MODE_PULSE) || (phase_q < duty);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] seed;
`ifdef STRESS_LFSR_EN
    // i+1, folded so that narrow LFSRs never get the all-zero lock-up seed.
    localparam longint unsigned SEED = (64'(i) % ((64'd1 << WIDTH) - 64'd1)) + 64'd1;
    assign seed = WIDTH'(SEED);
`else
    assign seed = '0;
`endif
    assign run[i] = gate_c && (ACT_W'(i) < active_q);

    stress_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run[i]),
      .seed    (seed),
      .value   (ch_val[i])
    );
  end

  // XOR of every channel bit; keeps the whole array observable.
  always_comb begin
    sig_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) sig_c = sig_c ^ (^ch_val[i]);
  end

  assign active_channels = active_q;
  assign ramp_done       = ramp_done_q;
  assign signature       = sig_q;
  assign heartbeat       = ch_val[0][WIDTH-1];

endmodule

// File: tb/tb_stress_toggle_array.sv
// Directed bench for stress_toggle_array: reset, ramp timing, aborts,
// PULSE duty counting, wrap/heartbeat and signature.
module tb_stress_toggle_array;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       a_en, b_en, c_en;
  logic [1:0] a_mode, b_mode, c_mode;
  logic [7:0] a_duty, b_duty, c_duty;
  logic [5:0] a_act;
  logic [2:0] b_act;
  logic [1:0] c_act;
  logic       a_rd, b_rd, c_rd;
  logic       a_sig, b_sig, c_sig;
  logic       a_hb, b_hb, c_hb;

  int checks = 0;
  int errors = 0;

  stress_toggle_array dut_a (
    .clk(clk), .reset_n(reset_n), .enable(a_en), .mode(a_mode), .duty(a_duty),
    .active_channels(a_act), .ramp_done(a_rd), .signature(a_sig), .heartbeat(a_hb)
  );

  stress_toggle_array #(.NUM_CHANNELS(4), .WIDTH(16), .RAMP_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(b_en), .mode(b_mode), .duty(b_duty),
    .active_channels(b_act), .ramp_done(b_rd), .signature(b_sig), .heartbeat(b_hb)
  );

  stress_toggle_array #(.NUM_CHANNELS(2), .WIDTH(4), .RAMP_CYCLES(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(c_en), .mode(c_mode), .duty(c_duty),
    .active_channels(c_act), .ramp_done(c_rd), .signature(c_sig), .heartbeat(c_hb)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Counter-value checks only hold for the binary-counter channels.
  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] expv);
`ifndef STRESS_LFSR_EN
    chk(tag, obs, expv);
`endif
  endtask

  function automatic logic [3:0] step4(input logic [3:0] v);
`ifdef STRESS_LFSR_EN
    return {v[2:0], v[3] ^ v[2]};
`else
    return v + 4'd1;
`endif
  endfunction

  logic [3:0] m0, m1;
  logic       prev_sig;

  initial begin
    reset_n = 1'b0;
    a_en = 1'b1; a_mode = 2'd2; a_duty = 8'd0;
    b_en = 1'b0; b_mode = 2'd0; b_duty = 8'd0;
    c_en = 1'b0; c_mode = 2'd0; c_duty = 8'd0;

    // Reset held with a FULL request pending.
    tick(5);
    chk("rst_act", 32'(a_act), 32'd0);
    chk("rst_rd", 32'(a_rd), 32'd0);
    chk("rst_sig", 32'(a_sig), 32'd0);
    chk("rst_hb", 32'(a_hb), 32'd0);
    chk_cnt("rst_ch0", 32'(dut_a.ch_val[0]), 32'd0);
    chk_cnt("rst_ch31", 32'(dut_a.ch_val[31]), 32'd0);

    reset_n = 1'b1;
    tick(2);
    chk("full_act", 32'(a_act), 32'd32);
    chk("full_rd", 32'(a_rd), 32'd0);
    chk_cnt("full_ch0", 32'(dut_a.ch_val[0]), 32'd1);
    chk_cnt("full_ch31", 32'(dut_a.ch_val[31]), 32'd1);

    // Ramp: one channel every 4 cycles.
    b_en = 1'b1; b_mode = 2'd1;
    tick(1);
    chk("ramp_entry_act", 32'(b_act), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      chk("ramp_act", 32'(b_act), 32'(c / 4));
      chk("ramp_rd", 32'(b_rd), 32'(c == 16));
      chk_cnt("ramp_ch3", 32'(dut_b.ch_val[3]), 32'd0);
      chk_cnt("ramp_ch0", 32'(dut_b.ch_val[0]), (c > 4) ? 32'(c - 4) : 32'd0);
    end

    // Mode change RAMP->FULL while holding: one IDLE cycle, then HOLD.
    b_mode = 2'd2;
    tick(1);
    chk("mchg_idle_act", 32'(b_act), 32'd0);
    chk("mchg_idle_rd", 32'(b_rd), 32'd0);
    chk_cnt("mchg_idle_ch0", 32'(dut_b.ch_val[0]), 32'd13);
    chk_cnt("mchg_idle_ch3", 32'(dut_b.ch_val[3]), 32'd1);
    tick(1);
    chk("mchg_full_act", 32'(b_act), 32'd4);
    chk("mchg_full_rd", 32'(b_rd), 32'd0);

    // FULL->RAMP: IDLE gap, then ramp restarts from zero.
    b_mode = 2'd1;
    tick(1);
    chk("rr_idle_act", 32'(b_act), 32'd0);
    chk_cnt("rr_idle_ch3", 32'(dut_b.ch_val[3]), 32'd2);
    tick(1);
    chk("rr_entry_act", 32'(b_act), 32'd0);
    tick(3);
    chk("rr_pre_act", 32'(b_act), 32'd0);
    tick(1);
    chk("rr_act1", 32'(b_act), 32'd1);
    chk_cnt("rr_ch0", 32'(dut_b.ch_val[0]), 32'd14);
    tick(4);
    chk("rr_act2", 32'(b_act), 32'd2);
    chk_cnt("rr_ch0b", 32'(dut_b.ch_val[0]), 32'd18);

    // Enable drops at active=2: straight to IDLE, registers retained.
    b_en = 1'b0;
    tick(1);
    chk("abort_act", 32'(b_act), 32'd0);
    chk("abort_rd", 32'(b_rd), 32'd0);
    chk_cnt("abort_ch0", 32'(dut_b.ch_val[0]), 32'd19);
    tick(3);
    chk("abort_hold_act", 32'(b_act), 32'd0);
    chk_cnt("abort_hold_ch0", 32'(dut_b.ch_val[0]), 32'd19);
    chk_cnt("abort_hold_ch3", 32'(dut_b.ch_val[3]), 32'd2);

    // PULSE with duty 64, then 0, then 255, 1024 cycles each.
    b_en = 1'b1; b_mode = 2'd3; b_duty = 8'd64;
    tick(1);
    chk("pulse_act", 32'(b_act), 32'd4);
    chk("pulse_rd", 32'(b_rd), 32'd0);
    tick(1024);
    chk_cnt("pulse64_ch0", 32'(dut_b.ch_val[0]), 32'd275);
    chk_cnt("pulse64_ch3", 32'(dut_b.ch_val[3]), 32'd258);
    b_duty = 8'd0;
    tick(1024);
    chk_cnt("pulse0_ch0", 32'(dut_b.ch_val[0]), 32'd275);
    b_duty = 8'd255;
    tick(1024);
    chk_cnt("pulse255_ch0", 32'(dut_b.ch_val[0]), 32'd1295);
    chk_cnt("pulse255_ch3", 32'(dut_b.ch_val[3]), 32'd1278);
    chk("pulse255_rd", 32'(b_rd), 32'd0);

    // WIDTH=4, two channels, FULL: wrap, heartbeat and signature model.
`ifdef STRESS_LFSR_EN
    m0 = 4'd1; m1 = 4'd2;
`else
    m0 = 4'd0; m1 = 4'd0;
`endif
    chk("c_seed0", 32'(dut_c.ch_val[0]), 32'(m0));
    chk("c_seed1", 32'(dut_c.ch_val[1]), 32'(m1));
    c_en = 1'b1; c_mode = 2'd2;
    prev_sig = (^m0) ^ (^m1);
    tick(1);
    chk("c_act", 32'(c_act), 32'd2);
    chk("c_entry_sig", 32'(c_sig), 32'(prev_sig));
    for (int k = 0; k < 40; k++) begin
      prev_sig = (^m0) ^ (^m1);
      tick(1);
      m0 = step4(m0);
      m1 = step4(m1);
      chk("c_ch0", 32'(dut_c.ch_val[0]), 32'(m0));
      chk("c_ch1", 32'(dut_c.ch_val[1]), 32'(m1));
      chk("c_sig", 32'(c_sig), 32'(prev_sig));
      chk("c_hb", 32'(c_hb), 32'(m0[3]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
